iccm_loader: RTL and testbench
==============================

ICCM_LOADER -- requirements
Module: iccm_loader

Interface
REQ-001 Parameter ADDR_W, default 12, meaning ICCM word-address width.
REQ-002 Parameter END_WORD, default 32'h0000_0FFF, meaning the assembled word that terminates a load.
REQ-003 Parameter GAP_CYC, default 1024, meaning the maximum idle cycles between bytes of one word; 0 disables the check.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 start_i  input  1  single-cycle request to begin or restart a program load.
REQ-007 rx_byte_i  input  8  received program byte.
REQ-008 rx_valid_i  input  1  rx_byte_i valid this cycle; no backpressure, every valid byte in RECV is consumed.
REQ-009 iccm_ctrl_addr_o  output  ADDR_W  ICCM word address for the current write.
REQ-010 iccm_ctrl_wdata_o  output  32  ICCM write data.
REQ-011 iccm_ctrl_we_o  output  1  single-cycle ICCM write strobe.
REQ-012 prog_rst_no  output  1  0 = loader owns ICCM, core held in reset; 1 = load complete, TL-UL path owns ICCM.
REQ-013 busy_o  output  1  high in RECV.
REQ-014 done_o  output  1  high in DONE.
REQ-015 err_o  output  1  high in ERR.
REQ-016 word_cnt_o  output  ADDR_W+1  number of words written in the current load.

Function
REQ-017 FSM states SHALL be IDLE, RECV, DONE, ERR; every output SHALL be registered.
REQ-018 IDLE: start_i -> RECV; rx_valid_i ignored.
REQ-019 RECV: each rx_valid_i byte SHALL be packed little-endian (1st byte -> [7:0], 4th byte -> [31:24]) using a 2-bit byte counter.
REQ-020 On the 4th byte, if word == END_WORD, FSM SHALL enter DONE next cycle, no write issued.
REQ-021 On the 4th byte, if word != END_WORD and word_cnt_o < 2**ADDR_W, iccm_ctrl_we_o SHALL pulse high exactly one cycle later, with wdata = word and addr = word_cnt_o[ADDR_W-1:0]; word_cnt_o SHALL increment in that same cycle.
REQ-022 On the 4th byte, if word != END_WORD and word_cnt_o == 2**ADDR_W, FSM SHALL enter ERR with no write issued (no address wrap).
REQ-023 Bytes arriving in the strobe cycle SHALL be accepted; minimum spacing between strobes is 4 cycles.
REQ-024 If GAP_CYC != 0 and the byte counter is non-zero with no rx_valid_i for GAP_CYC consecutive cycles, the partial word SHALL be discarded (byte counter -> 0); state and word_cnt_o are unchanged.
REQ-025 start_i in RECV SHALL be ignored.
REQ-026 DONE: prog_rst_no = 1; rx_valid_i ignored; start_i -> RECV with prog_rst_no = 0, word_cnt_o = 0, byte counter = 0 next cycle.
REQ-027 ERR: prog_rst_no = 0; rx_valid_i ignored; start_i -> RECV with counters cleared.
REQ-028 prog_rst_no SHALL be 0 in every state except DONE.
REQ-029 iccm_ctrl_we_o SHALL be 0 outside the strobe cycle; addr and wdata hold their last values between strobes.

Reset
REQ-030 rst_i SHALL take priority over all inputs, including the cycle of a pending strobe; the pending write is dropped.
REQ-031 Reset values: state IDLE, prog_rst_no 0, iccm_ctrl_we_o 0, iccm_ctrl_addr_o 0, iccm_ctrl_wdata_o 0, word_cnt_o 0, busy_o/done_o/err_o 0, byte and gap counters 0.

Verification
REQ-032 start_i, bytes 78 56 34 12 -> one strobe, addr 0x000, wdata 0x12345678, word_cnt_o 1.
REQ-033 Two data words, then FF 0F 00 00 -> two strobes at addr 0, 1; done_o=1, prog_rst_no=1, no third strobe.
REQ-034 ADDR_W=2: 4 data words, then a 5th data word -> 4 strobes, err_o=1, prog_rst_no=0; start_i -> busy_o=1, word_cnt_o=0.
REQ-035 GAP_CYC=8: 2 bytes, 8 idle cycles, then 78 56 34 12 -> a single strobe with wdata 0x12345678.
REQ-036 rst_i asserted in the cycle after the 4th byte -> no strobe; all outputs at reset values.
REQ-037 In DONE, rx_valid_i bytes -> no strobes; start_i -> prog_rst_no=0 next cycle, new load starts at addr 0.

Source files
------------

// File: rtl/iccm_loader.sv
// ICCM program loader: packs a little-endian byte stream into 32-bit words, writes
// them to consecutive ICCM addresses and releases the core once the end marker arrives.
module iccm_loader #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF,
    parameter int          GAP_CYC  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_valid_i,
    output logic [ADDR_W-1:0] iccm_ctrl_addr_o,
    output logic [31:0]       iccm_ctrl_wdata_o,
    output logic              iccm_ctrl_we_o,
    output logic              prog_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       part_q, part_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              pend_q, pend_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, done_q, err_q, prog_q;
    logic [31:0]       full_word_s;

    assign full_word_s = {rx_byte_i, part_q};

    // Next-state logic; a completed word is staged in pend_q so reset can still drop it.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        part_d      = part_q;
        gap_d       = gap_q;
        pend_d      = 1'b0;
        pend_data_d = pend_data_q;
        word_cnt_d  = word_cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if (pend_q) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = pend_data_q;
            word_cnt_d = word_cnt_q + CNT_ONE;
        end else begin
            we_d = 1'b0;
        end
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d    = RECV;
                    word_cnt_d = '0;
                    byte_cnt_d = 2'd0;
                    gap_d      = '0;
                end else begin
                    state_d = state_q;
                end
            end
            RECV: begin
                if (rx_valid_i) begin
                    gap_d = '0;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        if (full_word_s == END_WORD) begin
                            state_d = DONE;
                        end else if (word_cnt_q == MAX_WORDS) begin
                            state_d = ERR;
                        end else begin
                            pend_d      = 1'b1;
                            pend_data_d = full_word_s;
                        end
                    end else begin
                        part_d[8*byte_cnt_q +: 8] = rx_byte_i;
                        byte_cnt_d                = byte_cnt_q + 2'd1;
                    end
                end else if ((GAP_CYC != 0) && (byte_cnt_q != 2'd0)) begin
                    // Stalled partial word: throw it away after GAP_CYC idle cycles.
                    if (gap_q == GW'(GAP_CYC - 1)) begin
                        byte_cnt_d = 2'd0;
                        gap_d      = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end else begin
                    gap_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 2'd0;
            part_q      <= 24'd0;
            gap_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= 32'd0;
            word_cnt_q  <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            prog_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            part_q      <= part_d;
            gap_q       <= gap_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            word_cnt_q  <= word_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= (state_d == RECV);
            done_q      <= (state_d == DONE);
            err_q       <= (state_d == ERR);
            prog_q      <= (state_d == DONE);
        end
    end

    assign iccm_ctrl_addr_o  = addr_q;
    assign iccm_ctrl_wdata_o = wdata_q;
    assign iccm_ctrl_we_o    = we_q;
    assign prog_rst_no       = prog_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign word_cnt_o        = word_cnt_q;

endmodule

// File: tb/tb_iccm_loader.sv
// Directed bench for iccm_loader, built with a 4-word ICCM and an 8-cycle byte gap limit.
module tb_iccm_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          we;
    logic          prog_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic [31:0] log_addr [0:15];
    logic [31:0] log_data [0:15];

    iccm_loader #(.ADDR_W(AW), .END_WORD(32'h0000_0FFF), .GAP_CYC(8)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .rx_byte_i         (rx_byte),
        .rx_valid_i        (rx_valid),
        .iccm_ctrl_addr_o  (addr),
        .iccm_ctrl_wdata_o (wdata),
        .iccm_ctrl_we_o    (we),
        .prog_rst_no       (prog_rst_n),
        .busy_o            (busy),
        .done_o            (done),
        .err_o             (err),
        .word_cnt_o        (word_cnt)
    );

    always #5 clk = ~clk;

    // Strobe log, sampled mid-cycle.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (strobes < 16) begin
                log_addr[strobes] = 32'(addr);
                log_data[strobes] = wdata;
            end
            strobes = strobes + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[8*i +: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_prog", 32'(prog_rst_n), 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);

        // Bytes in IDLE are ignored
        send_word(32'h0000_0FFF);
        chk("idle_ignore", {29'd0, busy, done, err}, 32'd0);

        // First word
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        chk("w0_pending_we", 32'(we), 32'd0);
        step();
        chk("w0_we", 32'(we), 32'd1);
        chk("w0_addr", 32'(addr), 32'd0);
        chk("w0_wdata", wdata, 32'h1234_5678);
        chk("w0_cnt", 32'(word_cnt), 32'd1);
        step();
        chk("w0_we_drop", 32'(we), 32'd0);
        chk("w0_hold", wdata, 32'h1234_5678);

        // Second word, then end marker
        send_word(32'hCAFE_BABE);
        send_word(32'h0000_0FFF);
        chk("end_done", 32'(done), 32'd1);
        chk("end_prog", 32'(prog_rst_n), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        step(); step();
        chk("end_strobes", 32'(strobes), 32'd2);
        chk("w1_addr", log_addr[1], 32'd1);
        chk("w1_data", log_data[1], 32'hCAFE_BABE);
        chk("end_cnt", 32'(word_cnt), 32'd2);

        // DONE ignores bytes; restart begins at address 0
        send_word(32'h0403_0201);
        step(); step();
        chk("done_ignore", 32'(strobes), 32'd2);
        chk("done_hold", 32'(done), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_prog", 32'(prog_rst_n), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_cnt", 32'(word_cnt), 32'd0);
        send_word(32'h1122_3344);
        step();
        chk("rs_we", 32'(we), 32'd1);
        chk("rs_addr", 32'(addr), 32'd0);
        chk("rs_wdata", wdata, 32'h1122_3344);

        // Fill the 4-word ICCM, then overflow
        send_word(32'hA000_0001);
        send_word(32'hA000_0002);
        send_word(32'hA000_0003);
        step();
        chk("full_cnt", 32'(word_cnt), 32'd4);
        chk("full_last_addr", 32'(addr), 32'd3);
        send_word(32'hA000_0004);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_prog", 32'(prog_rst_n), 32'd0);
        step(); step();
        chk("ovf_strobes", 32'(strobes), 32'd6);
        chk("ovf_cnt", 32'(word_cnt), 32'd4);
        pulse_start();
        chk("err_restart_busy", 32'(busy), 32'd1);
        chk("err_restart_cnt", 32'(word_cnt), 32'd0);
        chk("err_restart_err", 32'(err), 32'd0);

        // Stalled partial word is discarded after 8 idle cycles
        send_byte(8'hAA); send_byte(8'hBB);
        for (int i = 0; i < 8; i++) step();
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        step();
        chk("gap_we", 32'(we), 32'd1);
        chk("gap_wdata", wdata, 32'h1234_5678);
        chk("gap_addr", 32'(addr), 32'd0);
        step();
        chk("gap_strobes", 32'(strobes), 32'd7);

        // Reset in the strobe cycle drops the write
        send_word(32'hDEAD_BEEF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_we", 32'(we), 32'd0);
        chk("rstw_addr", 32'(addr), 32'd0);
        chk("rstw_wdata", wdata, 32'd0);
        chk("rstw_cnt", 32'(word_cnt), 32'd0);
        chk("rstw_flags", {28'd0, prog_rst_n, busy, done, err}, 32'd0);
        step(); step();
        chk("rstw_strobes", 32'(strobes), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
